// File: rtl/hdu_sb.sv
// Scoreboarded hazard detection unit: load-use countdown, long-op pending bits, stall/flush control.
// Optional perf counters are built when HDU_PERF_EN is defined.
module hdu_sb #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned AW       = $clog2(NREG),
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 3,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              br_flush_i,
    input  logic [AW-1:0]     IFID_rs1_i,
    input  logic [AW-1:0]     IFID_rs2_i,
    input  logic [AW-1:0]     IFID_rd_i,
    input  logic              IFID_rd_wren_i,
    input  logic [AW-1:0]     IDEX_rd_i,
    input  logic              IDEX_rd_wren_i,
    input  logic              IDEX_mem_rden_i,
    input  logic              IDEX_lop_i,
    input  logic              lop_ready_i,
    input  logic              lop_done_i,
    input  logic [AW-1:0]     lop_rd_i,
    output logic              pc_wren_o,
    output logic              IFID_wren_o,
    output logic              IFID_clear_o,
    output logic              IDEX_wren_o,
    output logic              IDEX_clear_o,
    output logic              EXMEM_clear_o,
    output logic              lop_start_o,
    output logic [PERF_W-1:0] perf_lu_o,
    output logic [PERF_W-1:0] perf_lop_o,
    output logic [PERF_W-1:0] perf_fl_o
);

    logic [CNT_W-1:0] ld_cnt_q [NREG];
    logic [CNT_W-1:0] ld_cnt_d [NREG];
    logic [NREG-1:0]  lop_pend_q, lop_pend_d;

    logic ld_in_ex, rs1_hit, rs2_hit, waw_hit;
    logic struct_stall, data_stall, ex_adv, ld_set, lop_set;

    always_comb begin
        ld_in_ex = IDEX_mem_rden_i && IDEX_rd_wren_i;
        rs1_hit  = (IFID_rs1_i != '0) &&
                   ((ld_in_ex && (IDEX_rd_i == IFID_rs1_i)) ||
                    (ld_cnt_q[IFID_rs1_i] != '0) || lop_pend_q[IFID_rs1_i]);
        rs2_hit  = (IFID_rs2_i != '0) &&
                   ((ld_in_ex && (IDEX_rd_i == IFID_rs2_i)) ||
                    (ld_cnt_q[IFID_rs2_i] != '0) || lop_pend_q[IFID_rs2_i]);
        waw_hit  = IFID_rd_wren_i && (IFID_rd_i != '0) && lop_pend_q[IFID_rd_i];

        struct_stall = IDEX_lop_i && !lop_ready_i;
        data_stall   = rs1_hit || rs2_hit || waw_hit;
        ex_adv       = !br_flush_i && !struct_stall;
        lop_start_o  = IDEX_lop_i && lop_ready_i && !br_flush_i;
        ld_set       = ex_adv && ld_in_ex && (IDEX_rd_i != '0) && (LOAD_LAT > 1);
        lop_set      = lop_start_o && IDEX_rd_wren_i && (IDEX_rd_i != '0);
    end

    always_comb begin
        pc_wren_o     = 1'b1;
        IFID_wren_o   = 1'b1;
        IFID_clear_o  = 1'b0;
        IDEX_wren_o   = 1'b1;
        IDEX_clear_o  = 1'b0;
        EXMEM_clear_o = 1'b0;
        if (br_flush_i) begin
            IFID_clear_o  = 1'b1;
            IDEX_clear_o  = 1'b1;
            EXMEM_clear_o = 1'b1;
        end else if (struct_stall) begin
            pc_wren_o     = 1'b0;
            IFID_wren_o   = 1'b0;
            IDEX_wren_o   = 1'b0;
            EXMEM_clear_o = 1'b1;
        end else if (data_stall) begin
            pc_wren_o     = 1'b0;
            IFID_wren_o   = 1'b0;
            IDEX_clear_o  = 1'b1;
        end
    end

    // A fresh load set overrides the decrement on the same register.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            ld_cnt_d[i] = (ld_cnt_q[i] != '0) ? ld_cnt_q[i] - 1'b1 : '0;
            if (ld_set && (IDEX_rd_i == AW'(i))) begin
                ld_cnt_d[i] = CNT_W'(LOAD_LAT - 1);
            end
        end
        lop_pend_d = lop_pend_q;
        if (lop_done_i) lop_pend_d[lop_rd_i] = 1'b0;
        if (lop_set)    lop_pend_d[IDEX_rd_i] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) ld_cnt_q[i] <= '0;
            lop_pend_q <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) ld_cnt_q[i] <= ld_cnt_d[i];
            lop_pend_q <= lop_pend_d;
        end
    end

`ifdef HDU_PERF_EN
    logic [PERF_W-1:0] perf_lu_q, perf_lop_q, perf_fl_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_lu_q  <= '0;
            perf_lop_q <= '0;
            perf_fl_q  <= '0;
        end else begin
            if (!br_flush_i && !struct_stall && data_stall) perf_lu_q <= perf_lu_q + 1'b1;
            if (!br_flush_i && struct_stall) perf_lop_q <= perf_lop_q + 1'b1;
            if (br_flush_i) perf_fl_q <= perf_fl_q + 1'b1;
        end
    end

    assign perf_lu_o  = perf_lu_q;
    assign perf_lop_o = perf_lop_q;
    assign perf_fl_o  = perf_fl_q;
`else
    assign perf_lu_o  = '0;
    assign perf_lop_o = '0;
    assign perf_fl_o  = '0;
`endif

endmodule

// File: tb/tb_hdu_sb.sv
// Directed bench for hdu_sb: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus stream.
module tb_hdu_sb;

    localparam int unsigned AW = 5;

    // Packed as {pc_wren, IFID_wren, IFID_clear, IDEX_wren, IDEX_clear, EXMEM_clear, lop_start}
    localparam logic [6:0] RUN    = 7'b1101000;
    localparam logic [6:0] RUN_ST = 7'b1101001;
    localparam logic [6:0] DSTALL = 7'b0001100;
    localparam logic [6:0] SSTALL = 7'b0000010;
    localparam logic [6:0] FLUSH  = 7'b1111110;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic br_flush_i;
    logic [AW-1:0] IFID_rs1_i, IFID_rs2_i, IFID_rd_i, IDEX_rd_i, lop_rd_i;
    logic IFID_rd_wren_i, IDEX_rd_wren_i, IDEX_mem_rden_i, IDEX_lop_i;
    logic lop_ready_i, lop_done_i;

    logic pc1, ifw1, ifc1, idw1, idc1, exc1, st1;
    logic pc3, ifw3, ifc3, idw3, idc3, exc3, st3;
    logic [31:0] lu1, lop1, fl1, lu3, lop3, fl3;
    logic [6:0] o1, o3;

    int n_checks = 0;
    int n_errors = 0;

    assign o1 = {pc1, ifw1, ifc1, idw1, idc1, exc1, st1};
    assign o3 = {pc3, ifw3, ifc3, idw3, idc3, exc3, st3};

    always #5 clk_i = ~clk_i;

    hdu_sb #(.LOAD_LAT(1)) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_flush_i(br_flush_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i), .IFID_rd_i(IFID_rd_i),
        .IFID_rd_wren_i(IFID_rd_wren_i), .IDEX_rd_i(IDEX_rd_i),
        .IDEX_rd_wren_i(IDEX_rd_wren_i), .IDEX_mem_rden_i(IDEX_mem_rden_i),
        .IDEX_lop_i(IDEX_lop_i), .lop_ready_i(lop_ready_i), .lop_done_i(lop_done_i),
        .lop_rd_i(lop_rd_i), .pc_wren_o(pc1), .IFID_wren_o(ifw1), .IFID_clear_o(ifc1),
        .IDEX_wren_o(idw1), .IDEX_clear_o(idc1), .EXMEM_clear_o(exc1), .lop_start_o(st1),
        .perf_lu_o(lu1), .perf_lop_o(lop1), .perf_fl_o(fl1)
    );

    hdu_sb #(.LOAD_LAT(3)) u_dut3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .br_flush_i(br_flush_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i), .IFID_rd_i(IFID_rd_i),
        .IFID_rd_wren_i(IFID_rd_wren_i), .IDEX_rd_i(IDEX_rd_i),
        .IDEX_rd_wren_i(IDEX_rd_wren_i), .IDEX_mem_rden_i(IDEX_mem_rden_i),
        .IDEX_lop_i(IDEX_lop_i), .lop_ready_i(lop_ready_i), .lop_done_i(lop_done_i),
        .lop_rd_i(lop_rd_i), .pc_wren_o(pc3), .IFID_wren_o(ifw3), .IFID_clear_o(ifc3),
        .IDEX_wren_o(idw3), .IDEX_clear_o(idc3), .EXMEM_clear_o(exc3), .lop_start_o(st3),
        .perf_lu_o(lu3), .perf_lop_o(lop3), .perf_fl_o(fl3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        br_flush_i      = 1'b0;
        IFID_rs1_i      = '0;
        IFID_rs2_i      = '0;
        IFID_rd_i       = '0;
        IFID_rd_wren_i  = 1'b0;
        IDEX_rd_i       = '0;
        IDEX_rd_wren_i  = 1'b0;
        IDEX_mem_rden_i = 1'b0;
        IDEX_lop_i      = 1'b0;
        lop_ready_i     = 1'b1;
        lop_done_i      = 1'b0;
        lop_rd_i        = '0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load_in_ex(input logic [AW-1:0] rd);
        IDEX_mem_rden_i = 1'b1;
        IDEX_rd_wren_i  = 1'b1;
        IDEX_rd_i       = rd;
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        #2;
        check("rst_out1", {25'd0, o1}, {25'd0, RUN});
        check("rst_out3", {25'd0, o3}, {25'd0, RUN});
        check("rst_perf_lu", lu3, 32'd0);
        check("rst_perf_fl", fl3, 32'd0);
        #10 rst_ni = 1'b1;
        tick();

        // T1/T2: load x5 in EX, dependent rs1=x5 in ID
        load_in_ex(5'd5);
        IFID_rs1_i = 5'd5;
        #1;
        check("t1_c0_l1", {25'd0, o1}, {25'd0, DSTALL});
        check("t2_c0_l3", {25'd0, o3}, {25'd0, DSTALL});
        tick();
        idle();
        IFID_rs1_i = 5'd5;
        #1;
        check("t1_c1_l1", {25'd0, o1}, {25'd0, RUN});
        check("t2_c1_l3", {25'd0, o3}, {25'd0, DSTALL});
        tick();
        check("t2_c2_l3", {25'd0, o3}, {25'd0, DSTALL});
        tick();
        check("t2_c3_l3", {25'd0, o3}, {25'd0, RUN});
        check("t2_c3_l1", {25'd0, o1}, {25'd0, RUN});

        // Load to x0 never stalls
        idle();
        load_in_ex(5'd0);
        #1;
        check("t2_x0_l3", {25'd0, o3}, {25'd0, RUN});
        tick();
        idle();
        #1;
        check("t2_x0n_l3", {25'd0, o3}, {25'd0, RUN});

        // Independent instr behind load, then a dependent one hits the countdown
        load_in_ex(5'd5);
        IFID_rs2_i = 5'd6;
        #1;
        check("t2_ind_l3", {25'd0, o3}, {25'd0, RUN});
        tick();
        idle();
        IFID_rs2_i = 5'd5;
        #1;
        check("t2_cnt2_l3", {25'd0, o3}, {25'd0, DSTALL});
        check("t2_cnt2_l1", {25'd0, o1}, {25'd0, RUN});
        tick();
        check("t2_cnt1_l3", {25'd0, o3}, {25'd0, DSTALL});
        tick();
        check("t2_cnt0_l3", {25'd0, o3}, {25'd0, RUN});
        idle();

        // T3: long-op to x7, dependent reader stalls until lop_done
        IDEX_lop_i     = 1'b1;
        IDEX_rd_wren_i = 1'b1;
        IDEX_rd_i      = 5'd7;
        #1;
        check("t3_start1", {25'd0, o1}, {25'd0, RUN_ST});
        check("t3_start3", {25'd0, o3}, {25'd0, RUN_ST});
        tick();
        idle();
        lop_ready_i = 1'b0;
        IFID_rs2_i  = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t3_wait%0d", i), {25'd0, o1}, {25'd0, DSTALL});
            tick();
        end
        IFID_rs2_i     = 5'd0;
        IFID_rd_i      = 5'd7;
        IFID_rd_wren_i = 1'b1;
        #1;
        check("t3_waw", {25'd0, o3}, {25'd0, DSTALL});
        IFID_rd_wren_i = 1'b0;
        IFID_rs1_i     = 5'd7;
        lop_done_i     = 1'b1;
        lop_rd_i       = 5'd7;
        #1;
        check("t3_done_cyc", {25'd0, o1}, {25'd0, DSTALL});
        tick();
        lop_done_i = 1'b0;
        #1;
        check("t3_release1", {25'd0, o1}, {25'd0, RUN});
        check("t3_release3", {25'd0, o3}, {25'd0, RUN});
        idle();

        // T4: long-op held in EX while unit busy
        IDEX_lop_i     = 1'b1;
        IDEX_rd_wren_i = 1'b1;
        IDEX_rd_i      = 5'd9;
        lop_ready_i    = 1'b0;
        IFID_rs1_i     = 5'd9;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_busy%0d", i), {25'd0, o3}, {25'd0, SSTALL});
            tick();
        end
        lop_ready_i = 1'b1;
        IFID_rs1_i  = 5'd0;
        #1;
        check("t4_start", {25'd0, o3}, {25'd0, RUN_ST});
        tick();
        idle();
        lop_done_i = 1'b1;
        lop_rd_i   = 5'd9;
        tick();
        idle();
`ifdef HDU_PERF_EN
        check("t4_perf_lop", lop3, 32'd4);
`else
        check("t4_perf_lop", lop3, 32'd0);
`endif

        // T5: flush during a load-use stall
        load_in_ex(5'd5);
        IFID_rs1_i = 5'd5;
        br_flush_i = 1'b1;
        #1;
        check("t5_flush1", {25'd0, o1}, {25'd0, FLUSH});
        check("t5_flush3", {25'd0, o3}, {25'd0, FLUSH});
        tick();
        idle();
        IFID_rs1_i = 5'd5;
        #1;
        check("t5_noset3", {25'd0, o3}, {25'd0, RUN});
`ifdef HDU_PERF_EN
        check("t5_perf_fl", fl3, 32'd1);
`else
        check("t5_perf_fl", fl3, 32'd0);
`endif
        idle();

        // T6: async reset clears pending lop and load countdown
        IDEX_lop_i     = 1'b1;
        IDEX_rd_wren_i = 1'b1;
        IDEX_rd_i      = 5'd8;
        tick();
        idle();
        load_in_ex(5'd5);
        tick();
        idle();
        IFID_rs1_i = 5'd8;
        IFID_rs2_i = 5'd5;
        #1;
        check("t6_pre1", {25'd0, o1}, {25'd0, DSTALL});
        check("t6_pre3", {25'd0, o3}, {25'd0, DSTALL});
        rst_ni = 1'b0;
        #1;
        check("t6_rst1", {25'd0, o1}, {25'd0, RUN});
        check("t6_rst3", {25'd0, o3}, {25'd0, RUN});
        check("t6_rst_perf", fl3, 32'd0);
        tick();
        rst_ni = 1'b1;
        idle();
        load_in_ex(5'd5);
        IFID_rs1_i = 5'd5;
        #1;
        check("t6_reld3", {25'd0, o3}, {25'd0, DSTALL});
        tick();
        idle();
        IFID_rs1_i = 5'd5;
        #1;
        check("t6_after1", {25'd0, o1}, {25'd0, RUN});
        check("t6_after3", {25'd0, o3}, {25'd0, DSTALL});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
